// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data SRAM between the core data port (r0)
// and the loader/debug port (r1). Optional statistics counters: define DMEM_ARB_STATS_EN.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_r0_req,
    input  logic              i_r0_wen,
    input  logic [ADDR_W-1:0] i_r0_addr,
    input  logic [DATA_W-1:0] i_r0_wdata,
    output logic              o_r0_gnt,
    output logic              o_r0_rvalid,
    output logic [DATA_W-1:0] o_r0_rdata,
    input  logic              i_r1_req,
    input  logic              i_r1_wen,
    input  logic [ADDR_W-1:0] i_r1_addr,
    input  logic [DATA_W-1:0] i_r1_wdata,
    output logic              o_r1_gnt,
    output logic              o_r1_rvalid,
    output logic [DATA_W-1:0] o_r1_rdata,
    output logic              o_m_cen,
    output logic              o_m_wen,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_wdata,
    input  logic [DATA_W-1:0] i_m_rdata,
    output logic              o_busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       o_conflict_cnt,
    output logic [15:0]       o_stall_cnt
`endif
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ptr_r;
    logic             owner_r;

    logic             final_s;
    logic             arb_en_s;
    logic             gnt0_s;
    logic             gnt1_s;
    logic             rd_gnt_s;

    // The last latency cycle both returns data and may accept the next command.
    assign final_s  = (state_r == ST_WAIT) && (cnt_r == 2'd0);
    assign arb_en_s = (state_r == ST_IDLE) || final_s;
    assign rd_gnt_s = (gnt0_s | gnt1_s) & ~o_m_wen;
    assign o_busy   = (state_r == ST_WAIT);

    // Round-robin grant selection; the pointer only matters when both request.
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (arb_en_s) begin
            case ({i_r1_req, i_r0_req})
                2'b01: gnt0_s = 1'b1;
                2'b10: gnt1_s = 1'b1;
                2'b11: begin
                    gnt0_s = ~ptr_r;
                    gnt1_s = ptr_r;
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign o_r0_gnt = gnt0_s;
    assign o_r1_gnt = gnt1_s;

    // SRAM command mux: idle bus is driven to zero rather than left floating on a requester.
    always_comb begin
        o_m_cen   = 1'b0;
        o_m_wen   = 1'b0;
        o_m_addr  = {ADDR_W{1'b0}};
        o_m_wdata = {DATA_W{1'b0}};
        if (gnt0_s) begin
            o_m_cen   = 1'b1;
            o_m_wen   = i_r0_wen;
            o_m_addr  = i_r0_addr;
            o_m_wdata = i_r0_wdata;
        end else if (gnt1_s) begin
            o_m_cen   = 1'b1;
            o_m_wen   = i_r1_wen;
            o_m_addr  = i_r1_addr;
            o_m_wdata = i_r1_wdata;
        end else begin
            o_m_cen   = 1'b0;
            o_m_wen   = 1'b0;
            o_m_addr  = {ADDR_W{1'b0}};
            o_m_wdata = {DATA_W{1'b0}};
        end
    end

    // Read response routing: only the owner sees data, the other port holds zero.
    always_comb begin
        o_r0_rvalid = final_s & ~owner_r;
        o_r1_rvalid = final_s & owner_r;
        o_r0_rdata  = {DATA_W{1'b0}};
        o_r1_rdata  = {DATA_W{1'b0}};
        if (o_r0_rvalid) begin
            o_r0_rdata = i_m_rdata;
        end else begin
            o_r0_rdata = {DATA_W{1'b0}};
        end
        if (o_r1_rvalid) begin
            o_r1_rdata = i_m_rdata;
        end else begin
            o_r1_rdata = {DATA_W{1'b0}};
        end
    end

    // Arbiter state, latency counter, read owner and round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 2'd0;
            ptr_r   <= 1'b0;
            owner_r <= 1'b0;
        end else begin
            if (gnt0_s | gnt1_s) begin
                ptr_r <= gnt0_s;
            end else begin
                ptr_r <= ptr_r;
            end
            case (state_r)
                ST_IDLE, ST_WAIT: begin
                    if (arb_en_s) begin
                        if (rd_gnt_s) begin
                            state_r <= ST_WAIT;
                            owner_r <= gnt1_s;
                            cnt_r   <= CNT_LOAD;
                        end else begin
                            state_r <= ST_IDLE;
                            cnt_r   <= 2'd0;
                        end
                    end else begin
                        cnt_r <= cnt_r - 2'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 2'd0;
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    logic conflict_s;
    logic stall_s;

    assign conflict_s = i_r0_req & i_r1_req & arb_en_s;
    assign stall_s    = (i_r0_req | i_r1_req) & ~arb_en_s;

    // Saturating event counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_conflict_cnt <= 16'd0;
            o_stall_cnt    <= 16'd0;
        end else begin
            if (conflict_s && (o_conflict_cnt != 16'hFFFF)) begin
                o_conflict_cnt <= o_conflict_cnt + 16'd1;
            end else begin
                o_conflict_cnt <= o_conflict_cnt;
            end
            if (stall_s && (o_stall_cnt != 16'hFFFF)) begin
                o_stall_cnt <= o_stall_cnt + 16'd1;
            end else begin
                o_stall_cnt <= o_stall_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle corner sequences
// and a randomized phase checked against a cycle-indexed reference model.
module tb_dmem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          r0_req, r0_wen, r1_req, r1_wen;
    logic [AW-1:0] r0_addr, r1_addr;
    logic [DW-1:0] r0_wdata, r1_wdata;
    logic          r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic          m_cen, m_wen, busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   conflict_cnt, stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_r0_req(r0_req), .i_r0_wen(r0_wen), .i_r0_addr(r0_addr), .i_r0_wdata(r0_wdata),
        .o_r0_gnt(r0_gnt), .o_r0_rvalid(r0_rvalid), .o_r0_rdata(r0_rdata),
        .i_r1_req(r1_req), .i_r1_wen(r1_wen), .i_r1_addr(r1_addr), .i_r1_wdata(r1_wdata),
        .o_r1_gnt(r1_gnt), .o_r1_rvalid(r1_rvalid), .o_r1_rdata(r1_rdata),
        .o_m_cen(m_cen), .o_m_wen(m_wen), .o_m_addr(m_addr), .o_m_wdata(m_wdata),
        .i_m_rdata(m_rdata), .o_busy(busy)
`ifdef DMEM_ARB_STATS_EN
        , .o_conflict_cnt(conflict_cnt), .o_stall_cnt(stall_cnt)
`endif
    );

    // Behavioural SRAM: read data appears LAT cycles after a read command, garbage otherwise.
    logic [DW-1:0] sram [int unsigned];
    logic [DW-1:0] rpipe [0:LAT-1];
    assign m_rdata = rpipe[LAT-1];

    always @(posedge clk) begin
        if (m_cen && !m_wen)
            rpipe[0] <= sram.exists(m_addr) ? sram[m_addr] : 32'h0;
        else
            rpipe[0] <= 32'hBAD0_BAD0;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
        if (m_cen && m_wen) sram[m_addr] = m_wdata;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic req, input logic wen,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (which == 0) begin
            r0_req = req; r0_wen = wen; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_req = req; r1_wen = wen; r1_addr = addr; r1_wdata = wdata;
        end
    endtask

    task automatic do_reset();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Directed single-cycle vectors
    typedef struct {
        logic          r0_req, r0_wen;
        logic [AW-1:0] r0_addr;
        logic [DW-1:0] r0_wdata;
        logic          r1_req, r1_wen;
        logic [AW-1:0] r1_addr;
        logic [DW-1:0] r1_wdata;
        logic          g0, g1, cen, wen;
        logic [AW-1:0] maddr;
        logic [DW-1:0] mwdata;
    } vec_t;

    vec_t tbl [8];

    function automatic vec_t mkvec(logic q0, logic w0, logic [31:0] a0, logic [31:0] d0,
                                   logic q1, logic w1, logic [31:0] a1, logic [31:0] d1,
                                   logic g0, logic g1, logic cen, logic wen,
                                   logic [31:0] ma, logic [31:0] md);
        vec_t v;
        v.r0_req = q0; v.r0_wen = w0; v.r0_addr = a0; v.r0_wdata = d0;
        v.r1_req = q1; v.r1_wen = w1; v.r1_addr = a1; v.r1_wdata = d1;
        v.g0 = g0; v.g1 = g1; v.cen = cen; v.wen = wen; v.maddr = ma; v.mwdata = md;
        return v;
    endfunction

    // Reference model: time-indexed view of the single outstanding read
    typedef struct {
        logic          g0, g1, cen, wen, rv0, rv1, busy;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata, rd0, rd1;
    } exp_t;

    logic [DW-1:0] refmem [int unsigned];
    logic          m_ptr, m_pend, m_owner;
    int            m_due, cyc;
    logic [DW-1:0] m_data;

    function automatic exp_t model_expect();
        exp_t e;
        logic fin, arb;
        fin = m_pend && (cyc == m_due);
        arb = !m_pend || fin;
        e.g0 = arb && r0_req && (!r1_req || !m_ptr);
        e.g1 = arb && r1_req && (!r0_req || m_ptr);
        e.cen   = e.g0 || e.g1;
        e.wen   = e.g0 ? r0_wen   : (e.g1 ? r1_wen   : 1'b0);
        e.addr  = e.g0 ? r0_addr  : (e.g1 ? r1_addr  : 32'h0);
        e.wdata = e.g0 ? r0_wdata : (e.g1 ? r1_wdata : 32'h0);
        e.rv0 = fin && !m_owner;
        e.rv1 = fin && m_owner;
        e.rd0 = e.rv0 ? m_data : 32'h0;
        e.rd1 = e.rv1 ? m_data : 32'h0;
        e.busy = m_pend;
        return e;
    endfunction

    task automatic model_commit(input exp_t e);
        if (e.cen) m_ptr = e.g0;
        if (e.cen && !e.wen) begin
            m_pend  = 1'b1;
            m_owner = e.g1;
            m_due   = cyc + LAT;
            m_data  = refmem.exists(e.addr) ? refmem[e.addr] : 32'h0;
        end else if (m_pend && cyc == m_due) begin
            m_pend = 1'b0;
        end
        if (e.cen && e.wen) refmem[e.addr] = e.wdata;
        cyc++;
    endtask

    initial begin
        exp_t e;
        logic          pend [2];
        logic          wen_v [2];
        logic [AW-1:0] addr_v [2];
        logic [DW-1:0] data_v [2];
        logic          last_g [2];

        tbl[0] = mkvec(0,0,32'h0,32'h0,          0,0,32'h0,32'h0,          0,0,0,0,32'h0,32'h0);
        tbl[1] = mkvec(1,1,32'h1,32'hA1,         1,1,32'h2,32'hB2,         1,0,1,1,32'h1,32'hA1);
        tbl[2] = mkvec(1,1,32'h3,32'hA3,         1,1,32'h2,32'hB2,         0,1,1,1,32'h2,32'hB2);
        tbl[3] = mkvec(1,1,32'h3,32'hA3,         1,1,32'h4,32'hB4,         1,0,1,1,32'h3,32'hA3);
        tbl[4] = mkvec(1,1,32'h5,32'hA5,         1,1,32'h4,32'hB4,         0,1,1,1,32'h4,32'hB4);
        tbl[5] = mkvec(0,1,32'h5,32'hA5,         1,1,32'h6,32'hB6,         0,1,1,1,32'h6,32'hB6);
        tbl[6] = mkvec(0,0,32'h0,32'h0,          0,0,32'h0,32'h0,          0,0,0,0,32'h0,32'h0);
        tbl[7] = mkvec(1,1,32'h10,32'hDEADBEEF,  0,0,32'h0,32'h0,          1,0,1,1,32'h10,32'hDEADBEEF);

        do_reset();
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_rvalid", {r0_rvalid, r1_rvalid}, 2'b00);
        check("rst_rdata", {r0_rdata, r1_rdata}, 64'h0);
        check("rst_cen", {m_cen, m_wen, r0_gnt, r1_gnt}, 4'h0);
        check("rst_maddr", m_addr, 32'h0);

        // Table: round-robin write sequence and single write
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(0, tbl[i].r0_req, tbl[i].r0_wen, tbl[i].r0_addr, tbl[i].r0_wdata);
            drive(1, tbl[i].r1_req, tbl[i].r1_wen, tbl[i].r1_addr, tbl[i].r1_wdata);
            #1;
            check($sformatf("vec%0d_gnt", i), {r0_gnt, r1_gnt}, {tbl[i].g0, tbl[i].g1});
            check($sformatf("vec%0d_cmd", i), {m_cen, m_wen}, {tbl[i].cen, tbl[i].wen});
            check($sformatf("vec%0d_addr", i), m_addr, tbl[i].maddr);
            check($sformatf("vec%0d_wdata", i), m_wdata, tbl[i].mwdata);
            check($sformatf("vec%0d_busy", i), busy, 1'b0);
        end

        // Read return to r1
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check("rd_gnt", {r0_gnt, r1_gnt, m_cen, m_wen}, 4'b0110);
        check("rd_addr", m_addr, 32'h10);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
            #1;
            check($sformatf("rd_busy_t%0d", k), busy, 1'b1);
            check($sformatf("rd_r1_rvalid_t%0d", k), r1_rvalid, (k == LAT));
            check($sformatf("rd_r1_rdata_t%0d", k), r1_rdata, (k == LAT) ? 32'hDEADBEEF : 32'h0);
            check($sformatf("rd_r0_rvalid_t%0d", k), {r0_rvalid, r0_rdata}, 33'h0);
        end
        @(negedge clk);
        #1;
        check("rd_done_busy", busy, 1'b0);

        // Stall: r1 requests during r0's read, granted on the data-return cycle
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        check("st_gnt0", r0_gnt, 1'b1);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            drive(1, 1'b1, 1'b1, 32'h20, 32'h1234);
            #1;
            check($sformatf("st_gnt1_t%0d", k), {r1_gnt, m_cen}, (k == LAT) ? 2'b11 : 2'b00);
            check($sformatf("st_rvalid0_t%0d", k), r0_rvalid, (k == LAT));
            check($sformatf("st_rdata0_t%0d", k), r0_rdata, (k == LAT) ? 32'hDEADBEEF : 32'h0);
        end
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("st_done_busy", busy, 1'b0);

        // Reset asserted while a read is outstanding
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        check("rr_gnt0", r0_gnt, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        check("rr_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rr_busy_rst", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            #1;
            check($sformatf("rr_no_rvalid_%0d", k), {r0_rvalid, r1_rvalid}, 2'b00);
            @(negedge clk);
        end
        drive(0, 1'b1, 1'b1, 32'h30, 32'h3);
        drive(1, 1'b1, 1'b1, 32'h31, 32'h4);
        #1;
        check("rr_ptr_reset", {r0_gnt, r1_gnt}, 2'b10);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        m_ptr = 1'b0; m_pend = 1'b0; m_owner = 1'b0; m_due = 0; cyc = 0; m_data = 32'h0;
        for (int j = 0; j < 2; j++) begin
            pend[j] = 1'b0; last_g[j] = 1'b0;
            wen_v[j] = 1'b0; addr_v[j] = 32'h0; data_v[j] = 32'h0;
        end
        for (int n = 0; n < 1500; n++) begin
            if (n != 0) @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                if (last_g[j]) pend[j] = 1'b0;
                if (!pend[j]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        pend[j]   = 1'b1;
                        wen_v[j]  = $urandom_range(0, 1) == 1;
                        addr_v[j] = 32'h100 + 32'($urandom_range(0, 15));
                        data_v[j] = $urandom;
                    end
                end else if ($urandom_range(0, 99) < 3) begin
                    pend[j] = 1'b0;
                end
                drive(j, pend[j], wen_v[j], addr_v[j], data_v[j]);
            end
            #1;
            e = model_expect();
            check("rnd_gnt", {r0_gnt, r1_gnt}, {e.g0, e.g1});
            check("rnd_cmd", {m_cen, m_wen}, {e.cen, e.wen});
            check("rnd_addr", m_addr, e.addr);
            check("rnd_wdata", m_wdata, e.wdata);
            check("rnd_rvalid", {r0_rvalid, r1_rvalid}, {e.rv0, e.rv1});
            check("rnd_rdata", {r0_rdata, r1_rdata}, {e.rd0, e.rd1});
            check("rnd_busy", busy, e.busy);
            last_g[0] = e.g0;
            last_g[1] = e.g1;
            model_commit(e);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);

`ifdef DMEM_ARB_STATS_EN
        // Statistics counters: conflicts, WAIT stalls and saturation
        do_reset();
        #1;
        check("cnt_reset", {conflict_cnt, stall_cnt}, 32'h0);
        drive(0, 1'b1, 1'b1, 32'h40, 32'h1);
        drive(1, 1'b1, 1'b1, 32'h41, 32'h2);
        repeat (3) @(negedge clk);
        drive(0, 1'b1, 1'b0, 32'h40, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b1, 1'b1, 32'h41, 32'h5);
        repeat (LAT) @(negedge clk);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("cnt_conflict", conflict_cnt, 16'd3);
        check("cnt_stall", stall_cnt, 16'(LAT - 1));
        drive(0, 1'b1, 1'b1, 32'h50, 32'h0);
        drive(1, 1'b1, 1'b1, 32'h51, 32'h0);
        repeat (70000) @(negedge clk);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("cnt_conflict_sat", conflict_cnt, 16'hFFFF);
        check("cnt_stall_hold", stall_cnt, 16'(LAT - 1));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
